// File: rtl/spi_p_master_pkg.sv
// Shared types and constants for the spi_p_master block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_p_pkg;

    localparam int SPI_P_DIV_W    = 4;
    localparam int SPI_P_MAX_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } spi_p_state_t;

endpackage

// File: rtl/spi_p_master_clkgen.sv
// sclk phase divider: div_o counts 0..CLK_DIV-1 while enabled, phase_end_o marks the last count.
// Latency: phase_end_o is combinational from the registered count.
// Backpressure: none; clearing en_i parks the counter at 0.
module spi_p_clkgen
    import spi_p_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    output logic [SPI_P_DIV_W-1:0] div_o,
    output logic                   phase_end_o
);

    localparam logic [SPI_P_DIV_W-1:0] DIV_LAST = SPI_P_DIV_W'(CLK_DIV - 1);

    logic [SPI_P_DIV_W-1:0] div_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else if (!en_i || (div_q == DIV_LAST)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + SPI_P_DIV_W'(1);
        end
    end

    assign div_o       = div_q;
    assign phase_end_o = en_i && (div_q == DIV_LAST);

endmodule

// File: rtl/spi_p_master.sv
// Mode-0 SPI master, LSB first, active-high cs; SPI_P_MASTER_LOOPBACK_EN adds a rx-from-mosi port.
// Latency: cs rises the cycle after start; done pulses CLK_DIV*(2*DATA_BITS+2)+1 cycles after start.
// Backpressure: start is ignored while busy; start in the done cycle chains frames.
module spi_p_master
    import spi_p_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_BITS-1:0]   tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_BITS-1:0]   rx_data,
    output logic                   sclk,
    output logic                   cs,
    output logic                   mosi,
    input  logic                   miso,
`ifdef SPI_P_MASTER_LOOPBACK_EN
    input  logic                   loopback,
`endif
    output logic [SPI_P_DIV_W-1:0] div_counter
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(DATA_BITS);

    spi_p_state_t         state_q;
    logic [DATA_BITS-1:0] tx_q;
    logic [DATA_BITS-1:0] rx_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 sclk_q;
    logic                 cs_q;
    logic                 mosi_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 phase_end;
    logic                 cap_bit;
    logic [DATA_BITS-1:0] tx_d;
    logic [DATA_BITS-1:0] rx_d;

    spi_p_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i       (clk),
        .rst_ni      (reset),
        .en_i        (busy_q),
        .div_o       (div_counter),
        .phase_end_o (phase_end)
    );

`ifdef SPI_P_MASTER_LOOPBACK_EN
    logic lb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lb_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            lb_q <= loopback;
        end
    end

    assign cap_bit = lb_q ? mosi_q : miso;
`else
    assign cap_bit = miso;
`endif

    // Both registers shift right: tx exposes the next bit at [0], rx fills from the top so bit 0 lands LSB.
    assign tx_d = tx_q >> 1;
    assign rx_d = (rx_q >> 1) | (DATA_BITS'(cap_bit) << (DATA_BITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bit_idx_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_q      <= tx_data;
                        rx_q      <= '0;
                        bit_idx_q <= '0;
                        mosi_q    <= tx_data[0];
                        cs_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        sclk_q  <= 1'b1;
                        rx_q    <= rx_d;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        sclk_q    <= 1'b0;
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                        if (bit_idx_q != IDX_LAST) begin
                            tx_q   <= tx_d;
                            mosi_q <= tx_d[0];
                        end
                        state_q <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    // The final low phase still runs its full length before HOLD.
                    if (phase_end) begin
                        if (bit_idx_q == IDX_END) begin
                            state_q <= HOLD;
                        end else begin
                            sclk_q  <= 1'b1;
                            rx_q    <= rx_d;
                            state_q <= SHIFT_HI;
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        cs_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_p_master.sv
// Directed bench for spi_p_master: an 8-bit/CLK_DIV=4 instance plus a 1-bit/CLK_DIV=1 instance.
module tb_spi_p_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start1;
    logic [7:0] tx_data;
    logic [0:0] tx1;
    logic       busy, done, sclk, cs, mosi, miso;
    logic [7:0] rx_data;
    logic [3:0] div_counter;
    logic       busy1, done1, sclk1, cs1, mosi1, miso1;
    logic [0:0] rx1;
    logic [3:0] div1;
`ifdef SPI_P_MASTER_LOOPBACK_EN
    logic       loopback, loopback1;
`endif

    always #5 clk = ~clk;

    spi_p_master #(.DATA_BITS(8), .CLK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .cs(cs),
        .mosi(mosi), .miso(miso),
`ifdef SPI_P_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .div_counter(div_counter)
    );

    spi_p_master #(.DATA_BITS(1), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
        .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1), .cs(cs1),
        .mosi(mosi1), .miso(miso1),
`ifdef SPI_P_MASTER_LOOPBACK_EN
        .loopback(loopback1),
`endif
        .div_counter(div1)
    );

    // Slave model and frame observers, sampled on the falling clk edge.
    logic [7:0] slave_pat = 8'h00;
    logic [7:0] mosi_sh   = 8'h00;
    logic       sclk_prev = 1'b0, cs_prev = 1'b0, mosi_prev = 1'b0;
    int slave_idx = 0, cs_hi_cnt = 0, rise_cnt = 0, done_cnt = 0;
    int low_run = 0, last_gap = 0, mosi_viol = 0, div_max = 0;

    always @(negedge clk) begin
        if (cs) cs_hi_cnt += 1;
        else    low_run   += 1;
        if (cs && !cs_prev) begin
            last_gap = low_run;
            low_run  = 0;
        end
        if (sclk && !sclk_prev) begin
            rise_cnt += 1;
            mosi_sh = {mosi, mosi_sh[7:1]};
        end
        if (!sclk && sclk_prev) slave_idx += 1;
        if (!cs) slave_idx = 0;
        if (sclk && (mosi !== mosi_prev)) mosi_viol += 1;
        if (done) done_cnt += 1;
        if (int'(div_counter) > div_max) div_max = int'(div_counter);
        miso      = (slave_idx < 8) ? slave_pat[slave_idx[2:0]] : 1'b0;
        sclk_prev = sclk;
        cs_prev   = cs;
        mosi_prev = mosi;
    end

    logic sclk1_prev = 1'b0;
    int cs1_cnt = 0, sclk1_hi = 0, rise1 = 0;

    always @(negedge clk) begin
        if (cs1) cs1_cnt += 1;
        if (sclk1) sclk1_hi += 1;
        if (sclk1 && !sclk1_prev) rise1 += 1;
        sclk1_prev = sclk1;
    end

    int n_pass = 0, n_total = 0;
    int b_cs, b_rise, b_done, b_cs1, b_hi1, b_rise1;
    bit seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_frame(input logic [7:0] tx);
        @(negedge clk);
        tx_data = tx;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic snap();
        b_cs   = cs_hi_cnt;
        b_rise = rise_cnt;
        b_done = done_cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; start1 = 1'b0; tx_data = 8'h00; tx1 = 1'b0; miso1 = 1'b1;
`ifdef SPI_P_MASTER_LOOPBACK_EN
        loopback = 1'b0; loopback1 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_cs", cs, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        check("rst_div", div_counter, 0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        // Basic frame: send 0xA5, slave returns 0x3C.
        slave_pat = 8'h3C;
        snap();
        start_frame(8'hA5);
        check("acc_busy", busy, 1);
        check("acc_cs", cs, 1);
        check("acc_mosi", mosi, 1);
        check("acc_div", div_counter, 0);
        tx_data = 8'h00;
        wait_done(200, seen);
        check("f1_done_seen", seen, 1);
        check("f1_rx", rx_data, 8'h3C);
        check("f1_busy_at_done", busy, 0);
        check("f1_cs_at_done", cs, 0);
        @(posedge clk);
        check("f1_cs_cycles", cs_hi_cnt - b_cs, 72);
        check("f1_rises", rise_cnt - b_rise, 8);
        check("f1_mosi_bits", mosi_sh, 8'hA5);
        check("f1_done_cnt", done_cnt - b_done, 1);
        check("f1_div_max", div_max, 3);
        check("f1_mosi_stable", mosi_viol, 0);
        @(negedge clk);
        check("f1_done_pulse", done, 0);

        // start while busy is ignored.
        snap();
        start_frame(8'hA5);
        repeat (10) @(negedge clk);
        tx_data = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(200, seen);
        check("f2_done_seen", seen, 1);
        check("f2_rx", rx_data, 8'h3C);
        @(posedge clk);
        check("f2_mosi_bits", mosi_sh, 8'hA5);
        check("f2_rises", rise_cnt - b_rise, 8);
        repeat (20) @(negedge clk);
        check("f2_one_done", done_cnt - b_done, 1);
        check("f2_idle_cs", cs, 0);

        // Back-to-back frames with start held across done.
        snap();
        @(negedge clk);
        tx_data = 8'h81;
        start   = 1'b1;
        @(negedge clk);
        check("b2b_cs1", cs, 1);
        tx_data = 8'h7E;
        wait_done(200, seen);
        check("b2b_done1_seen", seen, 1);
        check("b2b_rx1", rx_data, 8'h3C);
        slave_pat = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        check("b2b_cs2", cs, 1);
        check("b2b_busy2", busy, 1);
        wait_done(200, seen);
        check("b2b_done2_seen", seen, 1);
        check("b2b_rx2", rx_data, 8'hC3);
        @(posedge clk);
        check("b2b_gap", last_gap, 1);
        check("b2b_mosi2", mosi_sh, 8'h7E);
        check("b2b_done_cnt", done_cnt - b_done, 2);
        check("b2b_rises", rise_cnt - b_rise, 16);

        // Asynchronous reset mid-frame.
        snap();
        start_frame(8'h96);
        repeat (29) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("ar_cs", cs, 0);
        check("ar_sclk", sclk, 0);
        check("ar_busy", busy, 0);
        check("ar_rx", rx_data, 0);
        check("ar_div", div_counter, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("ar_no_done", done_cnt - b_done, 0);
        slave_pat = 8'hA5;
        snap();
        start_frame(8'h3C);
        wait_done(200, seen);
        check("ar_done_seen", seen, 1);
        check("ar_rx", rx_data, 8'hA5);
        @(posedge clk);
        check("ar_mosi_bits", mosi_sh, 8'h3C);
        check("ar_cs_cycles", cs_hi_cnt - b_cs, 72);

        // CLK_DIV=1, DATA_BITS=1 instance.
        b_cs1 = cs1_cnt; b_hi1 = sclk1_hi; b_rise1 = rise1;
        @(negedge clk);
        tx1    = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("d1_done_seen", seen, 1);
        check("d1_rx", rx1, 1);
        @(posedge clk);
        check("d1_cs_cycles", cs1_cnt - b_cs1, 4);
        check("d1_sclk_high", sclk1_hi - b_hi1, 1);
        check("d1_rises", rise1 - b_rise1, 1);

`ifdef SPI_P_MASTER_LOOPBACK_EN
        // Loopback: rx follows mosi, miso held low.
        slave_pat = 8'h00;
        loopback  = 1'b1;
        start_frame(8'h5A);
        loopback  = 1'b0;
        wait_done(200, seen);
        check("lb_done_seen", seen, 1);
        check("lb_rx", rx_data, 8'h5A);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_p_master.md
Name: spi_p_master

Overview:
- Mode-0-style SPI master that generates `sclk`, `cs` and `mosi` from the system clock and captures `miso`.
- Sits directly upstream of the SPI slave stage and drives its `sclk`/`cs`/`mosi`/`div_counter` inputs.
- Frames are `DATA_BITS` long, LSB first, with `cs` active-high.
- A parallel start/done handshake faces the host logic.

Parameters:
- DATA_BITS, 8, frame width in bits; range 1..16.
- CLK_DIV, 4, `sclk` half-period in `clk` cycles; range 1..16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a frame; sampled only while `busy`=0.
- tx_data  input  DATA_BITS  word to send; latched in the cycle `start` is accepted.
- busy  output  1  high from the cycle after acceptance until the cycle `done` pulses.
- done  output  1  single-cycle pulse when a frame completes.
- rx_data  output  DATA_BITS  captured word; updated in the `done` cycle, held otherwise.
- sclk  output  1  serial clock; idle low.
- cs  output  1  chip select; active-high.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.
- div_counter  output  4  current divider phase, 0..CLK_DIV-1; 0 when idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - `sclk`=0, `cs`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, `div_counter`=0.
  - State returns to IDLE and the shift registers clear.
  - Reset mid-frame aborts the frame: `cs` drops immediately and no `done` is issued.
- IDLE: `start`=1 latches `tx_data` into the tx shift register. Next cycle: state=SETUP, `cs`=1, `busy`=1, `mosi`=tx[0].
- SETUP:
  - Lasts CLK_DIV cycles, during which `div_counter` runs 0..CLK_DIV-1.
  - When it wraps, `sclk` rises and state goes to SHIFT_HI.
- SHIFT_HI:
  - In the cycle `sclk` goes high, capture `miso` into rx[bit_idx].
  - After CLK_DIV cycles, `sclk` falls and state goes to SHIFT_LO.
- SHIFT_LO:
  - On the falling edge, `bit_idx` increments and `mosi`=tx[bit_idx].
  - If `bit_idx` was DATA_BITS-1, go to HOLD and leave `mosi` unchanged.
  - Otherwise, after CLK_DIV cycles, `sclk` rises and state returns to SHIFT_HI.
- HOLD:
  - CLK_DIV cycles with `sclk`=0 and `cs`=1.
  - Then `cs`=0, `busy`=0, `done`=1 for one cycle, `rx_data`=rx, state=IDLE.
- Frame timing: `cs` is high for exactly CLK_DIV*(2*DATA_BITS+2) cycles. `sclk` produces exactly DATA_BITS rising edges.
- `mosi` changes only while `sclk` is low, which satisfies slave sampling on rising `sclk`.
- Back-to-back frames: `start`=1 in the `done` cycle is accepted, so `cs` re-rises the next cycle. Minimum `cs`-low gap is 1 `clk`.
- `start` while `busy`=1 is ignored. Changes to `tx_data` after acceptance have no effect.
- `bit_idx` is $clog2(DATA_BITS+1) bits wide. `div_counter` arithmetic is modulo CLK_DIV and never exceeds CLK_DIV-1.

Optional Feature:
- Macro: SPI_P_MASTER_LOOPBACK_EN.
- Defined: adds input port `loopback` (1 bit). When `loopback`=1 at frame acceptance, rx captures the internal `mosi` instead of `miso` for the whole frame; external pins behave unchanged.
- Not defined: the port is absent and `miso` is always sampled.

Decomposition:
- Package spi_p_pkg holds:
  - the state enum typedef (IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD);
  - SPI_P_DIV_W=4;
  - SPI_P_MAX_BITS=16.
- One sub-module, spi_p_clkgen:
  - divider that produces `div_counter` and a single-cycle `phase_end` strobe;
  - enabled by `busy`, cleared in IDLE.

Test Plan:
- DATA_BITS=8, CLK_DIV=4, tx_data=0xA5, slave returns 0x3C:
  - `mosi` bits at rising `sclk` are 1,0,1,0,0,1,0,1;
  - `rx_data`=0x3C at `done`;
  - `cs` high for 72 cycles; exactly 8 `sclk` rises.
- `start` pulsed again 10 cycles into a frame with tx_data=0xFF: ignored; the frame completes with 0xA5 sent and exactly one `done`.
- `start` held high across the `done` cycle: second frame begins with `cs` low for exactly 1 cycle; both `done` pulses seen; `rx_data` updates each time.
- reset=0 at cycle 30 of a frame: `cs`, `sclk`, `busy`, `rx_data` go to 0 asynchronously; no `done`; after release, the next `start` sends a full frame.
- CLK_DIV=1, DATA_BITS=1, tx_data=1, `miso`=1: `cs` high for 4 cycles, one `sclk` pulse of 1 cycle, `rx_data`=1.
- SPI_P_MASTER_LOOPBACK_EN defined, `loopback`=1, tx_data=0x5A, `miso` held 0: `rx_data`=0x5A.
